// File: rtl/eq_coef_sequencer.sv
// rtl/eq_coef_sequencer.sv - 3-band EQ coefficient generator with one shared MAC and a double-buffered coefficient store
module eq_coef_sequencer #(
  parameter int NTAPS = 26,
  parameter int CW    = 18,
  parameter int LW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter_n,
  input  logic signed [LW-1:0] bass_level,
  input  logic signed [LW-1:0] mid_level,
  input  logic signed [LW-1:0] treble_level,
  input  logic                 sample_tick,
  input  logic [4:0]           rd_addr,
  output logic signed [CW-1:0] rd_data,
  output logic                 coef_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = 25;
  localparam int RW = 10;

  localparam logic signed [RW-1:0] BASS_ROM [NTAPS] = '{
    10'sd2, 10'sd2, 10'sd3, 10'sd3, 10'sd4, 10'sd5, 10'sd6, 10'sd8, 10'sd10,
    10'sd11, 10'sd14, 10'sd16, 10'sd18, 10'sd21, 10'sd23, 10'sd26, 10'sd28,
    10'sd31, 10'sd33, 10'sd35, 10'sd37, 10'sd39, 10'sd40, 10'sd41, 10'sd42,
    10'sd42
  };

  localparam logic signed [RW-1:0] MID_ROM [NTAPS] = '{
    -10'sd1, -10'sd1, -10'sd2, -10'sd3, -10'sd4, -10'sd6, -10'sd9, -10'sd11,
    -10'sd14, -10'sd16, -10'sd18, -10'sd19, -10'sd19, -10'sd17, -10'sd13,
    -10'sd7, 10'sd1, 10'sd11, 10'sd22, 10'sd34, 10'sd47, 10'sd58, 10'sd69,
    10'sd78, 10'sd84, 10'sd87
  };

  localparam logic signed [RW-1:0] TREBLE_ROM [NTAPS] = '{
    -10'sd1, -10'sd1, 10'sd1, 10'sd2, 10'sd0, 10'sd0, 10'sd4, 10'sd8, 10'sd6,
    10'sd0, 10'sd4, 10'sd15, 10'sd11, -10'sd9, -10'sd15, 10'sd4, 10'sd7,
    -10'sd33, -10'sd67, -10'sd40, 10'sd0, -10'sd49, -10'sd155, -10'sd134,
    10'sd97, 10'sd344
  };

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC_B, S_MAC_M, S_MAC_T, S_WR, S_PEND, S_DONE
  } state_t;

  state_t               state;
  logic                 enter_q;
  logic                 pending;
  logic                 act;
  logic [4:0]           k;
  logic signed [AW-1:0] acc;
  logic signed [LW-1:0] bass_r;
  logic signed [LW-1:0] mid_r;
  logic signed [LW-1:0] treble_r;

  logic                 req;
  logic signed [RW-1:0] rom_sel;
  logic signed [LW-1:0] lvl_sel;
  logic signed [AW-1:0] prod;
  logic signed [CW-1:0] wr_val;

  logic signed [CW-1:0] bank0 [NTAPS];
  logic signed [CW-1:0] bank1 [NTAPS];

  assign req = !enter_n && enter_q;

  // One multiplier shared by the three band passes; operands chosen by state.
  always_comb begin
    rom_sel = '0;
    lvl_sel = '0;
    case (state)
      S_MAC_B: begin rom_sel = BASS_ROM[k];   lvl_sel = bass_r;   end
      S_MAC_M: begin rom_sel = MID_ROM[k];    lvl_sel = mid_r;    end
      S_MAC_T: begin rom_sel = TREBLE_ROM[k]; lvl_sel = treble_r; end
      default: begin rom_sel = '0;            lvl_sel = '0;       end
    endcase
    prod   = AW'(rom_sel) * AW'(lvl_sel);
    wr_val = CW'(acc / AW'(3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      enter_q    <= 1'b1;
      pending    <= 1'b0;
      act        <= 1'b0;
      k          <= '0;
      acc        <= '0;
      bass_r     <= '0;
      mid_r      <= '0;
      treble_r   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      coef_valid <= 1'b0;
    end else begin
      enter_q <= enter_n;
      done    <= 1'b0;
      if (req && state != S_IDLE) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          bass_r   <= bass_level;
          mid_r    <= mid_level;
          treble_r <= treble_level;
          k        <= '0;
          acc      <= '0;
          state    <= S_MAC_B;
        end
        S_MAC_B: begin
          acc   <= acc + prod;
          state <= S_MAC_M;
        end
        S_MAC_M: begin
          acc   <= acc + prod;
          state <= S_MAC_T;
        end
        S_MAC_T: begin
          acc   <= acc + prod;
          state <= S_WR;
        end
        S_WR: begin
          acc <= '0;
          if (k == 5'(NTAPS - 1)) begin
            state <= S_PEND;
          end else begin
            k     <= k + 5'd1;
            state <= S_MAC_B;
          end
        end
        S_PEND: begin
          if (sample_tick) begin
            act        <= ~act;
            coef_valid <= 1'b1;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          // A request landing in this very cycle is honoured like a pending one.
          if (pending || req) begin
            pending <= 1'b0;
            state   <= S_LOAD;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Shadow bank is whichever one the read port is not using.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WR) begin
      if (act) bank0[k] <= wr_val;
      else     bank1[k] <= wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!coef_valid || rd_addr >= 5'(NTAPS)) begin
      rd_data <= '0;
    end else begin
      rd_data <= act ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

endmodule

// File: doc/eq_coef_sequencer.md
Name: eq_coef_sequencer

Overview:
- Computes the 26 symmetric FIR coefficients for the 3-band graphic equalizer filter from the bass, mid and treble gain levels.
- Uses one shared multiply-accumulate unit, sequenced over time.
- Writes results into a shadow bank of a double-buffered coefficient store. Swaps banks only on a filter sample boundary, so the filter never reads a mix of old and new coefficients.
- Sits between the user-control inputs and the filter datapath. The filter reads coefficients through a registered read port.

Parameters:
- NTAPS, 26, number of unique coefficients (half-length plus centre). Must be 26 to match the built-in band tables.
- CW, 18, signed coefficient width.
- LW, 5, signed gain-level width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- enter_n  in  1  active-low apply request, synchronous level; a request is its 1->0 transition
- bass_level  in  LW  signed gain, -16..15
- mid_level  in  LW  signed gain
- treble_level  in  LW  signed gain
- sample_tick  in  1  one-cycle pulse at each filter sample boundary
- rd_addr  in  5  coefficient index to read
- rd_data  out  CW  signed coefficient, registered
- coef_valid  out  1  active bank holds computed coefficients
- busy  out  1  computation or swap in progress
- done  out  1  one-cycle pulse after a bank swap

Behaviour:
- Band ROMs, listed as index 0..25 (25 = centre tap):
  - bass: 2,2,3,3,4,5,6,8,10,11,14,16,18,21,23,26,28,31,33,35,37,39,40,41,42,42
  - mid: -1,-1,-2,-3,-4,-6,-9,-11,-14,-16,-18,-19,-19,-17,-13,-7,1,11,22,34,47,58,69,78,84,87
  - treble: -1,-1,1,2,0,0,4,8,6,0,4,15,11,-9,-15,4,7,-33,-67,-40,0,-49,-155,-134,97,344
- Per-tap arithmetic:
  - coef[k] = (Bk*bass + Mk*mid + Tk*treble) / 3.
  - Signed products are accumulated in a 25-bit accumulator.
  - Division truncates toward zero.
  - Result is taken in CW bits; no saturation is needed, since |result| stays below 2^17.
- Edge detect: register enter_q, reset to 1. A request is enter_n==0 && enter_q==1.
- States:
  - IDLE: on a request -> LOAD.
  - LOAD (1 cycle): latch the three levels; k=0; acc=0; -> MAC_B.
  - MAC_B, MAC_M, MAC_T (1 cycle each): add Bk*bass, Mk*mid, Tk*treble to acc in turn.
  - WR (1 cycle): write acc/3 to shadow[k]; clear acc. If k==25 -> PEND, else k++ and -> MAC_B.
  - PEND: wait for sample_tick. On the tick cycle, flip the active-bank select and set coef_valid=1, then -> DONE.
  - DONE (1 cycle): done=1. If a request is pending -> LOAD (clear the pending flag), else -> IDLE.
- busy=1 in every state except IDLE.
- Latency: with the request detected at cycle E, LOAD is at E+1 and the last WR is at E+105. PEND is entered at E+106 at the earliest, so the swap happens at E+106 if a tick arrives then.
- A request while busy sets a single pending flag. Further requests while the flag is set are absorbed. Levels are sampled at the next LOAD, not at request time.
- sample_tick outside PEND is ignored.
- Read port:
  - rd_data is registered, 1-cycle latency, and always reads the active bank.
  - rd_addr > 25 returns 0.
  - Returns 0 while coef_valid==0.
  - During computation, reads return the previous coefficients unchanged.
- Reset (any cycle, including mid-computation):
  - state=IDLE; busy=0, done=0, coef_valid=0, rd_data=0.
  - Pending flag, accumulator and k are cleared; active bank = bank 0.
  - Bank RAM contents are not reset.

Test Plan:
- Reset, then bass=3, mid=0, treble=0, pulse enter_n low; tick held high -> busy rises at E+1. After done: rd_addr 25 -> 42, rd_addr 0 -> 2, rd_addr 13 -> 21, coef_valid=1, done is a single-cycle pulse.
- bass=0, mid=0, treble=-16 -> coef[25]=-1834, coef[24]=-517, coef[22]=826, coef[20]=0. Checks truncation toward zero.
- Tick gating: hold sample_tick=0 after the computation completes -> busy stays 1 and rd_data keeps the old values. A single tick -> new values visible on the read issued the next cycle.
- Request during computation (bass=3, then bass=-3 requested mid-run, plus two extra requests) -> exactly two swaps. Final coef[25]=-42 and coef[0]=-2.
- Assert rst at cycle E+50 -> busy=0 and coef_valid=0 next cycle, rd_data=0. A new request then completes normally with the expected values.
- Read rd_addr=30 with valid coefficients -> 0. Full sweep of addresses 0..25 against a golden model for levels (-16, 15, 7).
